// File: rtl/imem_loader.sv
// Boot loader: packs a little-endian byte stream into 32-bit words, writes them to
// instruction memory at consecutive word addresses, and holds the CPU until the image lands.
module imem_loader #(
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    input  logic              s_last,
    output logic              s_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    // word_index must be able to reach DEPTH to detect overflow
    localparam int unsigned IDX_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE,
        S_ERR
    } state_e;

    state_e state_q, state_d;

    logic              s_ready_q, s_ready_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [1:0]        lane_q, lane_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [31:0]       word_q, word_d;

    logic        xfer_c;
    logic        ovf_c;
    logic        word_end_c;
    logic [31:0] merged_c;

    assign xfer_c     = s_valid && s_ready_q;
    assign ovf_c      = xfer_c && (idx_q == IDX_W'(DEPTH));
    assign word_end_c = xfer_c && !ovf_c && ((lane_q == 2'd3) || s_last);
    // Partial word is cleared after every write, so unfilled lanes stay zero
    assign merged_c   = word_q | (32'(s_data) << {lane_q, 3'b000});

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_LOAD: begin
                if (ovf_c) begin
                    state_d = S_ERR;
                end else if (xfer_c && s_last) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                if (start) begin
                    state_d = S_LOAD;
                end
            end
        endcase
    end

    always_comb begin
        s_ready_d  = (state_d == S_LOAD);
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        cpu_hold_d = cpu_hold_q;
        done_d     = done_q;
        err_d      = err_q;
        lane_d     = lane_q;
        idx_d      = idx_q;
        word_d     = word_q;
        unique case (state_q)
            S_LOAD: begin
                if (ovf_c) begin
                    err_d      = 1'b1;
                    cpu_hold_d = 1'b1;
                end else if (word_end_c) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = ADDR_W'(idx_q) << 2;
                    wr_data_d = merged_c;
                    word_d    = '0;
                    lane_d    = '0;
                    idx_d     = idx_q + IDX_W'(1);
                    if (s_last) begin
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                    end
                end else if (xfer_c) begin
                    word_d = merged_c;
                    lane_d = lane_q + 2'd1;
                end
            end
            default: begin
                if (start) begin
                    lane_d     = '0;
                    idx_d      = '0;
                    word_d     = '0;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    cpu_hold_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_ready_q  <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            cpu_hold_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            lane_q     <= '0;
            idx_q      <= '0;
            word_q     <= '0;
        end else begin
            s_ready_q  <= s_ready_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            cpu_hold_q <= cpu_hold_d;
            done_q     <= done_d;
            err_q      <= err_d;
            lane_q     <= lane_d;
            idx_q      <= idx_d;
            word_q     <= word_d;
        end
    end

    assign s_ready  = s_ready_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign cpu_hold = cpu_hold_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule
